// File: rtl/sign_search.sv
// sign_search: exhaustive sign search over c0 +/- c1 +/- c2 +/- c3.
// After start, one sign code {c1s,c2s,c3s} is tried per cycle, 0 through 7,
// and the code whose exact sum lies closest to target is kept (lowest code wins ties).
// The winner is published with a one-cycle done pulse, ten cycles after start.
module sign_search (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] target,
    input  logic [15:0] c0,
    input  logic [15:0] c1,
    input  logic [15:0] c2,
    input  logic [15:0] c3,
    output logic        busy,
    output logic        done,
    output logic        c1s,
    output logic        c2s,
    output logic        c3s,
    output logic [15:0] sum,
    output logic [17:0] err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [15:0]        r_target;
    logic [15:0]        r_c0;
    logic [15:0]        r_c1;
    logic [15:0]        r_c2;
    logic [15:0]        r_c3;
    logic [2:0]         r_count;

    logic [2:0]         r_bestCode;
    logic [15:0]        r_bestSum;
    logic [17:0]        r_bestErr;

    logic               r_done;
    logic [2:0]         r_outCode;
    logic [15:0]        r_outSum;
    logic [17:0]        r_outErr;

    logic signed [18:0] w_term0;
    logic signed [18:0] w_term1;
    logic signed [18:0] w_term2;
    logic signed [18:0] w_term3;
    logic signed [18:0] w_exact;
    logic signed [18:0] w_diff;
    logic signed [18:0] w_absDiff;
    logic [17:0]        w_err;
    logic               w_better;

    // State register; reset drops straight back to IDLE even mid-search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: start is only looked at in IDLE, so it cannot queue.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = SEARCH;
            SEARCH:  if (r_count == 3'd7) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Signed evaluation of the current code; 19 bits hold every sum without wrap.
    always_comb begin
        w_term0   = $signed({3'b000, r_c0});
        w_term1   = r_count[2] ? -$signed({3'b000, r_c1}) : $signed({3'b000, r_c1});
        w_term2   = r_count[1] ? -$signed({3'b000, r_c2}) : $signed({3'b000, r_c2});
        w_term3   = r_count[0] ? -$signed({3'b000, r_c3}) : $signed({3'b000, r_c3});
        w_exact   = w_term0 + w_term1 + w_term2 + w_term3;
        w_diff    = $signed({3'b000, r_target}) - w_exact;
        w_absDiff = w_diff[18] ? -w_diff : w_diff;
        w_err     = w_absDiff[17:0];
        w_better  = (r_count == 3'd0) || (w_err < r_bestErr);
    end

    // Operand latch and code counter: inputs are captured only when start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= 16'd0;
            r_c0     <= 16'd0;
            r_c1     <= 16'd0;
            r_c2     <= 16'd0;
            r_c3     <= 16'd0;
            r_count  <= 3'd0;
        end else if (r_state == IDLE && start) begin
            r_target <= target;
            r_c0     <= c0;
            r_c1     <= c1;
            r_c2     <= c2;
            r_c3     <= c3;
            r_count  <= 3'd0;
        end else if (r_state == SEARCH) begin
            r_count  <= r_count + 3'd1;
        end
    end

    // Running best: code 0 always seeds it, later codes must be strictly better.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bestCode <= 3'd0;
            r_bestSum  <= 16'd0;
            r_bestErr  <= 18'd0;
        end else if (r_state == SEARCH && w_better) begin
            r_bestCode <= r_count;
            r_bestSum  <= w_exact[15:0];
            r_bestErr  <= w_err;
        end
    end

    // Result registers: loaded from the running best in DONE and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done    <= 1'b0;
            r_outCode <= 3'd0;
            r_outSum  <= 16'd0;
            r_outErr  <= 18'd0;
        end else if (r_state == DONE) begin
            r_done    <= 1'b1;
            r_outCode <= r_bestCode;
            r_outSum  <= r_bestSum;
            r_outErr  <= r_bestErr;
        end else begin
            r_done    <= 1'b0;
        end
    end

    assign busy = (r_state == SEARCH);
    assign done = r_done;
    assign c1s  = r_outCode[2];
    assign c2s  = r_outCode[1];
    assign c3s  = r_outCode[0];
    assign sum  = r_outSum;
    assign err  = r_outErr;

endmodule

// File: tb/tb_sign_search.sv
// Self-checking bench for sign_search: expected results are queued when a
// search is launched and popped when done is observed.
module tb_sign_search;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] target;
    logic [15:0] c0;
    logic [15:0] c1;
    logic [15:0] c2;
    logic [15:0] c3;
    logic        busy;
    logic        done;
    logic        c1s;
    logic        c2s;
    logic        c3s;
    logic [15:0] sum;
    logic [17:0] err;

    typedef struct packed {
        logic [2:0]  code;
        logic [15:0] sum;
        logic [17:0] err;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    sign_search dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .target (target),
        .c0     (c0),
        .c1     (c1),
        .c2     (c2),
        .c3     (c3),
        .busy   (busy),
        .done   (done),
        .c1s    (c1s),
        .c2s    (c2s),
        .c3s    (c3s),
        .sum    (sum),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic over all eight codes.
    function automatic exp_t modelSearch(input int t, input int a, input int b, input int c, input int d);
        exp_t r;
        int   bestE;
        int   ex;
        int   e;
        r     = '0;
        bestE = -1;
        for (int k = 0; k < 8; k++) begin
            ex = a + (((k >> 2) & 1) != 0 ? -b : b)
                   + (((k >> 1) & 1) != 0 ? -c : c)
                   + ((k & 1) != 0 ? -d : d);
            e  = t - ex;
            if (e < 0) e = -e;
            if (bestE < 0 || e < bestE) begin
                bestE  = e;
                r.code = 3'(k);
                r.sum  = ex[15:0];
                r.err  = bestE[17:0];
            end
        end
        return r;
    endfunction

    // Launch a search from a negedge, track busy per cycle, check done latency
    // and pop the scoreboard. disturbAt>0 pulses start and scrambles inputs then.
    task automatic runSearch(input logic [15:0] t, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d, input exp_t e,
                             input int disturbAt);
        exp_t got;
        exp_t want;
        logic seen;
        expQ.push_back(e);
        target = t; c0 = a; c1 = b; c2 = c; c3 = d;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 1'b0;
        for (int m = 1; m <= 14 && !seen; m++) begin
            @(negedge clk);
            if (m == disturbAt) begin
                target = 16'($urandom); c0 = 16'($urandom); c1 = 16'($urandom);
                c2 = 16'($urandom); c3 = 16'($urandom);
                start = 1'b1;
            end else if (m == disturbAt + 1) begin
                start = 1'b0;
            end
            checks++;
            if (busy !== (m <= 8)) begin
                errors++;
                $display("[TB] FAIL busy_cycle%0d: got %b expected %b", m, busy, (m <= 8));
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (m != 10) begin
                    errors++;
                    $display("[TB] FAIL done_latency: got cycle %0d expected cycle 10", m);
                end
                want = expQ.pop_front();
                got  = {c1s, c2s, c3s, sum, err};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL result: got code=%b sum=%h err=%0d expected code=%b sum=%h err=%0d",
                             got.code, got.sum, got.err, want.code, want.sum, want.err);
                end
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done expected done at cycle 10");
            void'(expQ.pop_front());
        end
    endtask

    // After a search, done must not repeat and outputs must hold.
    task automatic checkQuiet(input int cycles, input string name);
        exp_t held;
        held = {c1s, c2s, c3s, sum, err};
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || {c1s, c2s, c3s, sum, err} !== held) begin
                errors++;
                $display("[TB] FAIL %s: got done=%b busy=%b outs=%h expected done=0 busy=0 outs=%h",
                         name, done, busy, {c1s, c2s, c3s, sum, err}, held);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        target = 16'd0; c0 = 16'd0; c1 = 16'd0; c2 = 16'd0; c3 = 16'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, c1s, c2s, c3s, sum, err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected 0", {busy, done, c1s, c2s, c3s, sum, err});
        end
        rst_n = 1'b1;
        checkQuiet(3, "idle_after_reset");
    endtask

    task automatic test_basic();
        runSearch(16'd160, 16'd100, 16'd10, 16'd20, 16'd30, '{3'b000, 16'd160, 18'd0}, 0);
        checkQuiet(2, "single_done_a");
        runSearch(16'd40, 16'd100, 16'd10, 16'd20, 16'd30, '{3'b111, 16'd40, 18'd0}, 0);
        checkQuiet(2, "single_done_b");
        runSearch(16'd95, 16'd100, 16'd10, 16'd20, 16'd30, '{3'b001, 16'd100, 18'd5}, 0);
        checkQuiet(2, "single_done_c");
    endtask

    task automatic test_ties();
        runSearch(16'd5, 16'd0, 16'd0, 16'd0, 16'd0, '{3'b000, 16'd0, 18'd5}, 0);
        checkQuiet(1, "quiet_alltie");
        runSearch(16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, '{3'b001, 16'hFFFF, 18'd65535}, 0);
        checkQuiet(1, "quiet_nowrap");
    endtask

    task automatic test_random();
        logic [15:0] t, a, b, c, d;
        for (int i = 0; i < 6; i++) begin
            t = 16'($urandom); a = 16'($urandom); b = 16'($urandom);
            c = 16'($urandom_range(0, 300)); d = 16'($urandom);
            runSearch(t, a, b, c, d, modelSearch(int'(t), int'(a), int'(b), int'(c), int'(d)), 0);
            checkQuiet(1, "quiet_random");
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] t, a, b, c, d;
        for (int i = 0; i < 4; i++) begin
            t = 16'($urandom); a = 16'($urandom); b = 16'($urandom);
            c = 16'($urandom); d = 16'($urandom);
            runSearch(t, a, b, c, d, modelSearch(int'(t), int'(a), int'(b), int'(c), int'(d)), 0);
        end
        checkQuiet(3, "quiet_b2b");
    endtask

    task automatic test_ignore_midsearch();
        runSearch(16'd95, 16'd100, 16'd10, 16'd20, 16'd30, '{3'b001, 16'd100, 18'd5}, 3);
        checkQuiet(12, "one_done_midsearch");
    endtask

    task automatic test_reset_midsearch();
        target = 16'd40; c0 = 16'd100; c1 = 16'd10; c2 = 16'd20; c3 = 16'd30;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, c1s, c2s, c3s, sum, err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_midsearch: got %h expected 0", {busy, done, c1s, c2s, c3s, sum, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        checkQuiet(15, "no_done_after_reset");
        runSearch(16'd160, 16'd100, 16'd10, 16'd20, 16'd30, '{3'b000, 16'd160, 18'd0}, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_random();
        test_back_to_back();
        test_ignore_midsearch();
        test_reset_midsearch();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
